// File: rtl/serial_compare_pkg.sv
// -----------------------------------------------------------------------------
// serial_compare_pkg
//   Shared definitions for the digit-serial comparator: FSM state encodings,
//   default operand/digit widths for reuse by the ALU top level, and a helper
//   that sizes the digit counter.
// -----------------------------------------------------------------------------
package serial_compare_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DIGIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width for n digits: enough to hold n-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_cmp_digit.sv
// -----------------------------------------------------------------------------
// cmp_digit
//   Combinational compare of one DIGIT-wide slice of each operand.
//   Ports:
//     a_d   in  DIGIT  digit of operand A
//     b_d   in  DIGIT  digit of operand B
//     d_eq  out 1      a_d == b_d
//     d_gt  out 1      a_d >  b_d (unsigned)
// -----------------------------------------------------------------------------
module cmp_digit
    import serial_compare_pkg::*;
#(
    parameter int unsigned DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    output logic             d_eq,
    output logic             d_gt
);

    assign d_eq = (a_d == b_d);
    assign d_gt = (a_d >  b_d);

endmodule

// File: rtl/serial_compare.sv
// -----------------------------------------------------------------------------
// serial_compare
//   Digit-serial magnitude/equality comparator. Latches two WIDTH-bit operands
//   on an accepted start, compares DIGIT bits per clock from the MSB digit down,
//   exits at the first unequal digit and reports eq/lt/gt with a one-cycle done.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request, accepted only while ready
//     a, b   in   WIDTH  operands, sampled on the accepting edge
//     ready  out  1      IDLE or DONE
//     busy   out  1      RUN
//     done   out  1      one-cycle pulse when a result is produced
//     y_eq   out  1      a == b, held until the next accepted start
//     y_lt   out  1      a <  b, held
//     y_gt   out  1      a >  b, held
// -----------------------------------------------------------------------------
module serial_compare
    import serial_compare_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGIT  = DEF_DIGIT,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             y_eq,
    output logic             y_lt,
    output logic             y_gt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = cnt_width(NDIG);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(NDIG - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = {SIGNED, {(WIDTH-1){1'b0}}};

    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("serial_compare: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             dig_eq, dig_gt;

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d  (opa_q[WIDTH-1 -: DIGIT]),
        .b_d  (opb_q[WIDTH-1 -: DIGIT]),
        .d_eq (dig_eq),
        .d_gt (dig_gt)
    );

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign y_eq  = eq_q;
    assign y_lt  = lt_q;
    assign y_gt  = gt_q;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;

        case (state_q)
            ST_RUN: begin
                if (!dig_eq) begin
                    // Early exit: the first unequal digit decides the order.
                    gt_d    = dig_gt;
                    lt_d    = !dig_gt;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    opa_d = opa_q << DIGIT;
                    opb_d = opb_q << DIGIT;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                if (start && ready) begin
                    opa_d   = a ^ SIGN_FLIP;
                    opb_d   = b ^ SIGN_FLIP;
                    cnt_d   = CNT_LAST;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

endmodule

// File: tb/tb_serial_compare.sv
// -----------------------------------------------------------------------------
// tb_serial_compare
//   Drives an unsigned and a signed serial_compare with the same stimulus and
//   checks both against a latency/flag model computed from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_compare;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int ND = W / D;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    // index 0: SIGNED=0, index 1: SIGNED=1
    logic [1:0] ready, busy, done, y_eq, y_lt, y_gt;

    int n_checks = 0;
    int n_errors = 0;

    serial_compare #(.WIDTH(W), .DIGIT(D), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]),
        .y_eq(y_eq[0]), .y_lt(y_lt[0]), .y_gt(y_gt[0])
    );

    serial_compare #(.WIDTH(W), .DIGIT(D), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]),
        .y_eq(y_eq[1]), .y_lt(y_lt[1]), .y_gt(y_gt[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {eq, lt, gt} from whole-word arithmetic.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit sgn);
        logic eq, lt;
        eq = (x == y);
        lt = sgn ? ($signed(x) < $signed(y)) : (x < y);
        return {eq, lt, !eq && !lt};
    endfunction

    // Latency = 1-based digit index (from the MSB) of the highest differing bit.
    function automatic int ref_k(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] diff;
        diff = x ^ y;
        for (int i = W - 1; i >= 0; i--)
            if (diff[i]) return (W - 1 - i) / D + 1;
        return ND;
    endfunction

    function automatic logic [2:0] fl(input bit s);
        return {y_eq[s], y_lt[s], y_gt[s]};
    endfunction

    // Behavioural model per DUT: an accepted request occupies the unit for
    // ref_k cycles, then shows its result with a one-cycle done.
    for (genvar s = 0; s < 2; s++) begin : g_model
        int         rem;
        logic       mdone;
        logic [2:0] flags;
        logic [2:0] pend;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem   <= 0;
                mdone <= 1'b0;
                flags <= '0;
                pend  <= '0;
            end else if (rem > 1) begin
                rem   <= rem - 1;
                mdone <= 1'b0;
            end else if (rem == 1) begin
                rem   <= 0;
                mdone <= 1'b1;
                flags <= pend;
            end else begin
                mdone <= 1'b0;
                if (start) begin
                    rem   <= ref_k(a, b);
                    pend  <= ref_flags(a, b, s == 1);
                    flags <= '0;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("ready[%0d]", s), 64'(ready[s]), 64'(rem == 0));
            check($sformatf("busy[%0d]", s),  64'(busy[s]),  64'(rem != 0));
            check($sformatf("done[%0d]", s),  64'(done[s]),  64'(mdone));
            check($sformatf("flags[%0d]", s), 64'({y_eq[s], y_lt[s], y_gt[s]}), 64'(flags));
        end
    end

    // Issue one request (caller is at posedge+#1 with the DUTs ready) and count
    // edges from the accepting edge to done. Optional noise toggles start and the
    // operands while busy.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit noise,
                         output int lat);
        bit seen;
        seen  = 1'b0;
        lat   = 0;
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done[0]) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(1, 0));
                a     = $urandom;
                b     = $urandom;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'(1));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        int last;
        logic [W-1:0] xa, xb;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_ready", 64'(ready), 64'(2'b11));
        check("rst_busy",  64'(busy),  64'(2'b00));
        check("rst_done",  64'(done),  64'(2'b00));
        check("rst_flags", 64'({y_eq, y_lt, y_gt}), 64'(0));

        // 1: all-ones equal -> full latency, eq
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        check("t1_lat", 64'(lat), 64'(16));
        check("t1_u", 64'(fl(0)), 64'(3'b100));
        check("t1_s", 64'(fl(1)), 64'(3'b100));

        // 2: MSB differs -> 1 edge; unsigned gt, signed lt
        do_op(32'h8000_0000, 32'h0000_0000, 1'b0, lat);
        check("t2_lat", 64'(lat), 64'(1));
        check("t2_u", 64'(fl(0)), 64'(3'b001));
        check("t2_s", 64'(fl(1)), 64'(3'b010));

        // 3: difference only in the last digit
        do_op(32'h0000_0003, 32'h0000_0001, 1'b0, lat);
        check("t3_lat", 64'(lat), 64'(16));
        check("t3_u", 64'(fl(0)), 64'(3'b001));
        check("t3_s", 64'(fl(1)), 64'(3'b001));
        do_op(32'h0000_0001, 32'h0000_0003, 1'b0, lat);
        check("t3_swap_lat", 64'(lat), 64'(16));
        check("t3_swap_u", 64'(fl(0)), 64'(3'b010));

        // 4: start held high -> re-accepted every DONE cycle, period 17
        a = '0; b = '0; start = 1'b1;
        pulses = 0; last = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk); #1;
            if (done[0]) begin
                check("t4_period", 64'(i - last), 64'(pulses == 0 ? 17 : 17));
                check("t4_eq", 64'(fl(0)), 64'(3'b100));
                last = i;
                pulses++;
                if (pulses == 3) break;
            end
        end
        start = 1'b0;
        check("t4_pulses", 64'(pulses), 64'(3));

        // 5a: operand change and start while busy are ignored
        a = 32'h1; b = 32'h2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 32'h8000_0000; b = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        for (int i = 0; i < 30 && !done[0]; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t5_lat", 64'(lat), 64'(16));
        check("t5_u", 64'(fl(0)), 64'(3'b010));
        check("t5_s", 64'(fl(1)), 64'(3'b010));

        // 5b: reset in RUN cycle 5 abandons the operation
        a = 32'h5; b = 32'h5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 64'(ready), 64'(2'b11));
        check("t5_rst_busy",  64'(busy),  64'(2'b00));
        check("t5_rst_done",  64'(done),  64'(2'b00));
        check("t5_rst_flags", 64'({y_eq, y_lt, y_gt}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done != 2'b00) pulses++;
        end
        check("t5_no_done", 64'(pulses), 64'(0));
        check("t5_ready_after", 64'(ready), 64'(2'b11));

        // 6: random operations with varied decision depth
        for (int n = 0; n < 1000; n++) begin
            xa = $urandom;
            case ($urandom_range(3, 0))
                0:       xb = $urandom;
                1:       xb = xa;
                2:       xb = xa ^ (32'h1 << $urandom_range(31, 0));
                default: xb = {~xa[W-1], xa[W-2:0]} ^ (32'h1 << $urandom_range(7, 0));
            endcase
            do_op(xa, xb, 1'($urandom_range(1, 0)), lat);
            check("rnd_lat", 64'(lat), 64'(ref_k(xa, xb)));
            check("rnd_u", 64'(fl(0)), 64'(ref_flags(xa, xb, 1'b0)));
            check("rnd_s", 64'(fl(1)), 64'(ref_flags(xa, xb, 1'b1)));
            if ($urandom_range(3, 0) == 0) begin
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
